// File: rtl/equiv_pkg.sv
// equiv_pkg: shared types and constants for the exhaustive equivalence checker.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package equiv_pkg;

    localparam int VEC_COUNT = 16;   // every combination of the 4 stimulus bits
    localparam int VEC_W     = 4;
    localparam int RESP_W    = 5;
    localparam int ERR_W     = 5;    // holds 0..VEC_COUNT
    localparam int CNT_W     = 5;    // settle counter, holds up to SETTLE+1 = 16

    // Sweep sequencer states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        APPLY = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Response packing shared by both implementations: {o0,o1,o2[1:0],o3}.
    typedef struct packed {
        logic       o0;
        logic       o1;
        logic [1:0] o2;
        logic       o3;
    } resp_t;

    // Sweep scorecard, cleared on every accepted start.
    typedef struct packed {
        logic [ERR_W-1:0] err_count;
        logic [VEC_W-1:0] fail_vec;
        logic             fail_valid;
    } result_t;

    // Any single-bit difference between the two responses counts as a mismatch.
    function automatic logic resp_differs(input resp_t a, input resp_t b);
        return (a != b);
    endfunction

    // Error counter increment that sticks at VEC_COUNT instead of wrapping.
    function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
        return (v >= ERR_W'(VEC_COUNT)) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/equiv_vec_gen.sv
// equiv_vec_gen: vector index register plus settle counter timed from each vector's apply edge.
// Latency: index changes on the load/step edge; last rises SETTLE cycles after that edge.
// Backpressure: none; load and step are single-cycle commands from the sequencer.
module equiv_vec_gen
    import equiv_pkg::*;
#(
    parameter int SETTLE = 2        // legal 1..15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,   // restart at vector 0 (start of a sweep)
    input  logic             step,   // advance to the next vector
    output logic [VEC_W-1:0] index,
    output logic             last    // settle interval for the current vector has elapsed
);

    // The counter is 0 during the apply cycle, then 1..SETTLE through the wait cycles,
    // and parks at SETTLE+1 so it never wraps while the sequencer sits in IDLE or DONE.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SETTLE + 1);

    logic [CNT_W-1:0] settle_cnt;

    // Index changes only on load/step (the apply entry edge); settle count restarts there too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index      <= '0;
            settle_cnt <= '0;
        end else if (load) begin
            index      <= '0;
            settle_cnt <= '0;
        end else if (step) begin
            index      <= index + VEC_W'(1);
            settle_cnt <= '0;
        end else if (settle_cnt != CNT_SAT) begin
            settle_cnt <= settle_cnt + CNT_W'(1);
        end
    end

    assign last = (settle_cnt == CNT_LAST);

endmodule

// File: rtl/equiv_checker.sv
// equiv_checker: drives all 16 vectors to two implementations and scores response mismatches.
// Latency: 16*(SETTLE+2) cycles from the accepted start edge to the first cycle with done=1.
// Backpressure: none; start is ignored while busy, results hold in DONE until the next start.
module equiv_checker
    import equiv_pkg::*;
#(
    parameter int SETTLE = 2        // idle cycles between driving a vector and sampling, 1..15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [VEC_W-1:0]  stim,
    input  logic [RESP_W-1:0] resp_a,
    input  logic [RESP_W-1:0] resp_b,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [VEC_W-1:0]  fail_vec,
    output logic              fail_valid
);

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             step;
    logic             settled;
    logic [VEC_W-1:0] index;
    logic             mismatch;
    result_t          res;

    equiv_vec_gen #(
        .SETTLE (SETTLE)
    ) u_vec_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .index (index),
        .last  (settled)
    );

    // State register; reset abandons any sweep in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and vector-generator commands; start only matters in IDLE or DONE.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = APPLY;
                    load      = 1'b1;
                end
            end
            APPLY: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (settled) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                // Stop after the final vector rather than wrapping back to 0.
                if (index == VEC_W'(VEC_COUNT - 1)) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = APPLY;
                    step      = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign mismatch = (state == CHECK) && resp_differs(resp_t'(resp_a), resp_t'(resp_b));

    // Scorecard: cleared on an accepted start, counts mismatches, keeps the first failing vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res <= '0;
        end else if (load) begin
            res <= '0;
        end else if (mismatch) begin
            res.err_count <= err_sat_inc(res.err_count);
            if (!res.fail_valid) begin
                res.fail_vec   <= index;
                res.fail_valid <= 1'b1;
            end
        end
    end

    // Moore outputs decoded from the state register and the held scorecard.
    assign stim       = index;
    assign busy       = (state == APPLY) || (state == WAIT) || (state == CHECK);
    assign done       = (state == DONE);
    assign pass       = done && (res.err_count == '0);
    assign err_count  = res.err_count;
    assign fail_vec   = res.fail_vec;
    assign fail_valid = res.fail_valid;

endmodule

// File: tb/tb_equiv_checker.sv
module tb_equiv_checker;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       start5 = 1'b0;
    int         mode  = 0;
    int         cyc   = 0;
    int         s5    = -1;
    int         n_cmp = 0;
    int         n_fail = 0;

    // SETTLE=2 instance
    logic [3:0] stim;
    logic [4:0] resp_a, resp_b;
    logic       busy, done, pass, fail_valid;
    logic [4:0] err_count;
    logic [3:0] fail_vec;

    // SETTLE=5 instance
    logic [3:0] stim5;
    logic [4:0] resp_a5;
    logic       busy5, done5, pass5, fail_valid5;
    logic [4:0] err_count5;
    logic [3:0] fail_vec5;

    typedef struct {
        int         cyc;
        logic [4:0] err;
        logic [3:0] fv;
        logic       fvalid;
        logic       pass;
    } exp_t;

    exp_t q2[$];
    exp_t q5[$];
    exp_t cur2, cur5;
    logic have2 = 1'b0, have5 = 1'b0;
    logic done_q = 1'b0, done5_q = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in combinational function for the "implementation under test".
    function automatic logic [4:0] ref_resp(input logic [3:0] s);
        logic       o0, o1, o3;
        logic [1:0] o2;
        o0 = ^s;
        o1 = s[3] & s[0];
        o2 = s[1:0] ^ s[3:2];
        o3 = s[2] | s[1];
        return {o0, o1, o2, o3};
    endfunction

    function automatic logic [4:0] faulty(input logic [3:0] s, input int m);
        logic [4:0] a;
        a = ref_resp(s);
        case (m)
            1:       return a ^ ((s == 4'hA) ? 5'b00001 : 5'b00000);
            2:       return ~a;
            3:       return a ^ ((s == 4'h3 || s == 4'hC) ? 5'b10000 : 5'b00000);
            default: return a;
        endcase
    endfunction

    assign resp_a  = ref_resp(stim);
    assign resp_b  = faulty(stim, mode);
    assign resp_a5 = ref_resp(stim5);

    equiv_checker #(.SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(stim),
        .resp_a(resp_a), .resp_b(resp_b), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_vec(fail_vec), .fail_valid(fail_valid)
    );

    equiv_checker #(.SETTLE(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .stim(stim5),
        .resp_a(resp_a5), .resp_b(resp_a5), .busy(busy5), .done(done5), .pass(pass5),
        .err_count(err_count5), .fail_vec(fail_vec5), .fail_valid(fail_valid5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue a sweep on the SETTLE=2 instance and queue its expected result.
    task automatic issue(input int m, input logic [4:0] err, input logic [3:0] fv, input logic fvalid);
        exp_t e;
        mode     = m;
        start    = 1'b1;
        e.cyc    = cyc + 65;
        e.err    = err;
        e.fv     = fv;
        e.fvalid = fvalid;
        e.pass   = (err == 5'd0);
        q2.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: done not seen within 200 cycles", name);
        end
    endtask

    task automatic wait_done5(input string name);
        int n = 0;
        while (done5 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (done5 !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: done not seen within 200 cycles", name);
        end
    endtask

    // Monitor for SETTLE=2: score on done rising, then check results hold while in DONE.
    always @(negedge clk) begin
        if (done === 1'b1 && !done_q) begin
            if (q2.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: done rose with no sweep outstanding");
            end else begin
                cur2 = q2.pop_front();
                have2 = 1'b1;
                check("latency", cyc, cur2.cyc);
                check("err_count", err_count, cur2.err);
                check("fail_vec", fail_vec, cur2.fv);
                check("fail_valid", fail_valid, cur2.fvalid);
                check("pass", pass, cur2.pass);
                check("busy_in_done", busy, 1'b0);
            end
        end else if (done === 1'b1 && done_q && have2) begin
            check("hold_err", err_count, cur2.err);
            check("hold_fv", fail_vec, cur2.fv);
            check("hold_fvalid", fail_valid, cur2.fvalid);
            check("hold_pass", pass, cur2.pass);
            check("hold_stim", stim, 4'hF);
        end
        done_q <= done;
    end

    // Monitor for SETTLE=5: sweep result plus per-cycle stimulus sequence (7 cycles per vector).
    always @(negedge clk) begin
        if (busy5 === 1'b1 && s5 >= 0) begin
            check("stim5_seq", stim5, 32'((cyc - s5) / 7));
        end
        if (done5 === 1'b1 && !done5_q) begin
            if (q5.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done5: done rose with no sweep outstanding");
            end else begin
                cur5 = q5.pop_front();
                have5 = 1'b1;
                check("latency5", cyc, cur5.cyc);
                check("err_count5", err_count5, cur5.err);
                check("fail_valid5", fail_valid5, cur5.fvalid);
                check("pass5", pass5, cur5.pass);
            end
        end else if (done5 === 1'b1 && done5_q && have5) begin
            check("hold_stim5", stim5, 4'hF);
        end
        done5_q <= done5;
    end

    initial begin
        exp_t e5;

        // Asynchronous reset with no clock edge involved.
        #1 rst_n = 1'b0;
        #1;
        check("rst_stim", stim, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_err", err_count, 5'd0);
        check("rst_fv", fail_vec, 4'h0);
        check("rst_fvalid", fail_valid, 1'b0);
        check("rst_done5", done5, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // Identical implementations on both instances.
        issue(0, 5'd0, 4'h0, 1'b0);
        start5    = 1'b1;
        s5        = cyc + 1;
        e5.cyc    = cyc + 113;
        e5.err    = 5'd0;
        e5.fv     = 4'h0;
        e5.fvalid = 1'b0;
        e5.pass   = 1'b1;
        q5.push_back(e5);
        @(negedge clk);
        start  = 1'b0;
        start5 = 1'b0;
        wait_done("sweep_identical");
        wait_done5("sweep_settle5");

        // Single fault: o3 inverted only at vector A.
        @(negedge clk) issue(1, 5'd1, 4'hA, 1'b1);
        @(negedge clk) start = 1'b0;
        wait_done("sweep_single_fault");

        // Two faults at vectors 3 and C: first one must stick.
        @(negedge clk) issue(3, 5'd2, 4'h3, 1'b1);
        @(negedge clk) start = 1'b0;
        wait_done("sweep_two_faults");

        // All vectors differ, start held high for 40 cycles: one sweep only.
        @(negedge clk) issue(2, 5'd16, 4'h0, 1'b1);
        repeat (40) @(negedge clk);
        start = 1'b0;
        wait_done("sweep_all_fault_held_start");
        repeat (3) @(negedge clk);
        check("no_second_sweep", busy, 1'b0);
        check("done_stays", done, 1'b1);

        // Immediate restart from DONE: done drops as busy rises, scorecard cleared.
        issue(0, 5'd0, 4'h0, 1'b0);
        @(negedge clk) start = 1'b0;
        check("restart_done", done, 1'b0);
        check("restart_busy", busy, 1'b1);
        check("restart_err", err_count, 5'd0);
        check("restart_fvalid", fail_valid, 1'b0);
        check("restart_stim", stim, 4'h0);
        wait_done("sweep_restart");

        // Reset 30 cycles into an all-fault sweep.
        @(negedge clk);
        mode  = 2;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (29) @(negedge clk);
        check("mid_busy", busy, 1'b1);
        check("mid_err", err_count, 5'd7);
        check("mid_fvalid", fail_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_stim", stim, 4'h0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_pass", pass, 1'b0);
        check("arst_err", err_count, 5'd0);
        check("arst_fv", fail_vec, 4'h0);
        check("arst_fvalid", fail_valid, 1'b0);

        // Start accepted on the first edge after reset release, full-length sweep.
        @(negedge clk);
        rst_n = 1'b1;
        issue(1, 5'd1, 4'hA, 1'b1);
        @(negedge clk) start = 1'b0;
        wait_done("sweep_after_reset");

        @(negedge clk);
        check("q2_drained", q2.size(), 0);
        check("q5_drained", q5.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
